forward_broadcast: RTL and testbench
====================================

Name: forward_broadcast

Overview:
- Producer end of the result-forwarding buses: collects completed results (ROB tag + 16-bit value) from NUM_SRC functional units and drives up to four forwarding lanes per cycle.
- Lane format is identical on all four lanes: [22] valid, [21:16] rob, [15:0] value.
- Each source has a small FIFO with a ready/valid handshake. A round-robin arbiter picks up to 4 sources per cycle, one entry per source.
- Flush clears everything in flight on a mispredict.

Parameters:
- NUM_SRC, 6, number of result-producing units (4..8)
- DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  synchronous pipeline flush, discards all buffered results
- src_valid  in  NUM_SRC  per-source result valid
- src_rob  in  6*NUM_SRC  per-source ROB tag; source i at [6i+5:6i]
- src_value  in  16*NUM_SRC  per-source result value; source i at [16i+15:16i]
- src_ready  out  NUM_SRC  per-source registered ready
- forwardA  out  23  lane 0, registered: {valid, rob[5:0], value[15:0]}
- forwardB  out  23  lane 1, same format
- forwardC  out  23  lane 2, same format
- forwardD  out  23  lane 3, same format
- busy  out  1  any source FIFO non-empty (combinational from counts)

Behaviour:
- Reset (rst_n=0 at edge):
  - FIFOs emptied; counts=0; rr pointer=0.
  - forwardA..D=23'h0; src_ready=0.
  - busy=0 after the edge.
- src_ready[i] is a register, loaded each edge with (next count_i < DEPTH). It goes to 1 the first edge after reset release.
- Push: if src_valid[i] && src_ready[i] at an edge, {rob,value} enters FIFO i. If src_valid is high while src_ready is low, the source must hold; the entry is not taken.
- Arbitration:
  - Uses counts at cycle start. A value pushed in the same cycle is not eligible (no bypass).
  - Scan order is i = rr, rr+1, ..., rr+NUM_SRC-1 (mod NUM_SRC). The first up to 4 sources with count>0 are granted, in that order, to lanes A, B, C, D.
  - Each granted source pops its oldest entry (FIFO order kept per source).
- Lane outputs: a granted lane loads {1, rob, value}; an ungranted lane loads 23'h0.
- Latency: result accepted at edge k appears on a lane after edge k+1 at the earliest. A lane is valid for exactly one cycle per result.
- rr update: if any grant, rr <= (index of last granted source + 1) mod NUM_SRC. If no grant, rr unchanged.
- Simultaneous push and pop on the same source in one cycle: count unchanged, order preserved.
- Full FIFO: src_ready=0 for that cycle even if a pop occurs. Ready reasserts the next cycle.
- flush=1 at edge (takes priority over push and pop):
  - All counts=0; rr=0; all lanes=0.
  - Pushes that edge are discarded.
  - src_ready <= 1 for all sources.
- rst_n has priority over flush.
- With more than 4 sources non-empty, the others wait. Round-robin guarantees every non-empty source is granted within ceil(NUM_SRC/4) cycles.
- No two lanes ever carry the same source in one cycle. Lanes are filled contiguously from A; there are no gaps.
- Widths: rob 6 bits, value 16 bits, passed through unmodified. No arithmetic on data.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> all lanes 23'h0, busy=0; src_ready=6'b111111 one edge after release.
- Single result: src 2 pushes rob=6'h0A, value=16'h1234 at edge k -> after edge k+1 forwardA=23'h4A1234, forwardB..D=0, busy=0.
- Six simultaneous pushes, rob=i, value=16'h0100+i, rr=0 -> next cycle lanes A..D carry sources 0,1,2,3. The following cycle A=src4, B=src5, C=D=0. rr ends at 0.
- Backpressure: src 1 pushes on 3 consecutive edges while src 0 and src 2..5 stay continuously non-empty (DEPTH=2) -> src_ready[1] drops after the second accept. Third value is held by the source and accepted after a pop. Src 1 output order matches input order.
- Flush: load 5 entries, assert flush one cycle -> next cycle all lanes 0, busy=0, src_ready all 1. A push coincident with flush never appears on any lane.
- Fairness: sources 0..5 kept always non-empty for 6 cycles -> each source granted exactly 4 times. Lane A source sequence is 0,4,2,0,4,2.

Source files
------------

// File: rtl/forward_broadcast.sv
// forward_broadcast
//   Producer side of the result-forwarding buses. Each of NUM_SRC functional
//   units hands completed results (ROB tag + 16-bit value) into its own small
//   FIFO over a ready/valid handshake. Every cycle a round-robin arbiter grants
//   up to four non-empty sources, one entry each, onto forwarding lanes A..D.
//   A flush discards everything buffered.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low (has priority over flush)
//   flush      synchronous flush: empties FIFOs, clears lanes, rr pointer -> 0
//   src_valid  per-source result valid
//   src_rob    per-source ROB tag, source i at [6i+5:6i]
//   src_value  per-source value, source i at [16i+15:16i]
//   src_ready  per-source registered ready (next count < DEPTH)
//   forwardA..D  registered lanes {valid, rob[5:0], value[15:0]}
//   busy       any source FIFO non-empty (combinational from counts)
module forward_broadcast #(
  parameter int NUM_SRC = 6,
  parameter int DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [6*NUM_SRC-1:0]    src_rob,
  input  logic [16*NUM_SRC-1:0]   src_value,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [22:0]             forwardA,
  output logic [22:0]             forwardB,
  output logic [22:0]             forwardC,
  output logic [22:0]             forwardD,
  output logic                    busy
);

  localparam int SW    = $clog2(NUM_SRC);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LANES = 4;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LAST_C  = SW'(NUM_SRC - 1);

  typedef logic [21:0] entry_t;

  entry_t        mem_q    [NUM_SRC][DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_SRC];
  logic [PW-1:0] rd_ptr_q [NUM_SRC];
  logic [CW-1:0] cnt_q    [NUM_SRC];
  logic [CW-1:0] cnt_d    [NUM_SRC];
  logic [NUM_SRC-1:0] ready_q, ready_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [22:0]   lane_q [LANES];
  logic [22:0]   lane_d [LANES];

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] nonempty;
  logic [SW-1:0]      lane_src [LANES];
  logic [LANES-1:0]   lane_vld;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin scan starting at rr_q; first four non-empty sources fill
  // lanes A..D in scan order, so lanes are always contiguous from A.
  always_comb begin
    logic [2:0]    ngrant;
    logic [SW-1:0] idx;
    logic [SW-1:0] last;
    int unsigned   s;
    grant    = '0;
    lane_vld = '0;
    ngrant   = '0;
    last     = '0;
    idx      = '0;
    s        = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_src[l] = '0;
    end
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      s   = 32'(rr_q) + k;
      idx = (s >= NUM_SRC) ? SW'(s - NUM_SRC) : SW'(s);
      if (nonempty[idx] && (ngrant < 3'd4)) begin
        grant[idx]            = 1'b1;
        lane_vld[ngrant[1:0]] = 1'b1;
        lane_src[ngrant[1:0]] = idx;
        last                  = idx;
        ngrant                = ngrant + 3'd1;
      end
    end
    rr_d = rr_q;
    if (ngrant != 3'd0) begin
      rr_d = (last == LAST_C) ? '0 : last + SW'(1);
    end
  end

  // Counts and ready derive from counts at cycle start, so a result pushed
  // this cycle cannot be granted until the next one.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      push[i]    = src_valid[i] & ready_q[i];
      cnt_d[i]   = cnt_q[i] + CW'(push[i]) - CW'(grant[i]);
      ready_d[i] = (cnt_d[i] < DEPTH_C);
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_d[l] = '0;
      if (lane_vld[l]) begin
        lane_d[l] = {1'b1, mem_q[lane_src[l]][rd_ptr_q[lane_src[l]]]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      ready_q <= '0;
      rr_q    <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        lane_q[l] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      ready_q <= '1;
      rr_q    <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        lane_q[l] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        end
        if (grant[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
      end
      ready_q <= ready_d;
      rr_q    <= rr_d;
      for (int unsigned l = 0; l < LANES; l++) begin
        lane_q[l] <= lane_d[l];
      end
    end
  end

  // Storage needs no reset; counts decide what is live.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rst_n && !flush && push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {src_rob[6*i +: 6], src_value[16*i +: 16]};
      end
    end
  end

  assign src_ready = ready_q;
  assign busy      = |nonempty;
  assign forwardA  = lane_q[0];
  assign forwardB  = lane_q[1];
  assign forwardC  = lane_q[2];
  assign forwardD  = lane_q[3];

endmodule

// File: tb/tb_forward_broadcast.sv
// Self-checking bench for forward_broadcast (NUM_SRC=6, DEPTH=2).
// Accepted pushes go into per-source expected queues; every valid lane must
// match the oldest outstanding entry of some source.
module tb_forward_broadcast;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [5:0]  src_valid;
  logic [35:0] src_rob;
  logic [95:0] src_value;
  logic [5:0]  src_ready;
  logic [22:0] forwardA, forwardB, forwardC, forwardD;
  logic        busy;

  always #5 clk = ~clk;

  forward_broadcast #(.NUM_SRC(6), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_rob(src_rob), .src_value(src_value),
    .src_ready(src_ready),
    .forwardA(forwardA), .forwardB(forwardB), .forwardC(forwardC), .forwardD(forwardD),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  logic [21:0] sb [6][$];
  logic [5:0]  acc_q;
  logic [7:0]  seq [6];
  int          a_seq [6] = '{0, 4, 2, 0, 4, 2};
  int          grants [6];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record accepted pushes at the edge they happen.
  always @(posedge clk) begin
    acc_q = '0;
    if (!rst_n || flush) begin
      for (int i = 0; i < 6; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          sb[i].push_back({src_rob[6*i +: 6], src_value[16*i +: 16]});
          acc_q[i] = 1'b1;
        end
      end
    end
  end

  // Compare every lane against the scoreboard away from the active edge.
  always @(negedge clk) begin
    logic [22:0] ln [4];
    logic [3:0]  vb;
    logic [5:0]  used;
    int          found;
    if (rst_n) begin
      ln[0] = forwardA; ln[1] = forwardB; ln[2] = forwardC; ln[3] = forwardD;
      vb = {ln[0][22], ln[1][22], ln[2][22], ln[3][22]};
      check_eq("lane_contig", {28'd0, vb}, (vb inside {4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111}) ? {28'd0, vb} : 32'hFFFF);
      used = '0;
      for (int l = 0; l < 4; l++) begin
        if (ln[l][22]) begin
          found = -1;
          for (int s = 0; s < 6; s++) begin
            if (found < 0 && !used[s] && sb[s].size() > 0 && sb[s][0] == ln[l][21:0]) found = s;
          end
          check_eq($sformatf("lane%0d_expected_%06h", l, ln[l][21:0]), (found >= 0) ? 32'd1 : 32'd0, 32'd1);
          if (found >= 0) begin
            used[found] = 1'b1;
            void'(sb[found].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [5:0] r, input logic [15:0] v);
    src_rob[6*i +: 6]    = r;
    src_value[16*i +: 16] = v;
  endtask

  task automatic load_src(input int i);
    set_src(i, {3'(i), seq[i][2:0]}, {8'(i), seq[i]});
  endtask

  // Advance data only for sources whose current entry was taken.
  task automatic refresh();
    for (int i = 0; i < 6; i++) begin
      if (acc_q[i]) begin
        seq[i] = seq[i] + 8'd1;
        load_src(i);
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && busy; n++) tick();
    check_eq("drain_busy", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic check_lanes_zero(input string tag);
    check_eq({tag, "_A"}, {9'd0, forwardA}, 32'd0);
    check_eq({tag, "_B"}, {9'd0, forwardB}, 32'd0);
    check_eq({tag, "_C"}, {9'd0, forwardC}, 32'd0);
    check_eq({tag, "_D"}, {9'd0, forwardD}, 32'd0);
  endtask

  initial begin
    logic [22:0] exp_l;
    rst_n = 1'b0; flush = 1'b0; src_valid = '0; src_rob = '0; src_value = '0;
    for (int i = 0; i < 6; i++) seq[i] = 8'd0;

    // Reset and idle
    repeat (2) tick();
    check_lanes_zero("rst_lane");
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {26'd0, src_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_ready", {26'd0, src_ready}, 32'h3F);
    check_lanes_zero("rel_lane");
    check_eq("rel_busy", {31'd0, busy}, 32'd0);

    // Single result from source 2
    set_src(2, 6'h0A, 16'h1234);
    src_valid = 6'b000100;
    tick();
    src_valid = '0;
    check_eq("single_busy_k", {31'd0, busy}, 32'd1);
    check_eq("single_A_k", {9'd0, forwardA}, 32'd0);
    tick();
    check_eq("single_A", {9'd0, forwardA}, 32'h4A1234);
    check_eq("single_B", {9'd0, forwardB}, 32'd0);
    check_eq("single_C", {9'd0, forwardC}, 32'd0);
    check_eq("single_D", {9'd0, forwardD}, 32'd0);
    check_eq("single_busy", {31'd0, busy}, 32'd0);

    // Return rr to 0
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush0_ready", {26'd0, src_ready}, 32'h3F);

    // Six simultaneous pushes
    for (int i = 0; i < 6; i++) set_src(i, 6'(i), 16'(16'h0100 + i));
    src_valid = 6'h3F;
    tick();
    src_valid = '0;
    tick();
    exp_l = {1'b1, 6'd0, 16'h0100}; check_eq("six_A0", {9'd0, forwardA}, {9'd0, exp_l});
    exp_l = {1'b1, 6'd1, 16'h0101}; check_eq("six_B1", {9'd0, forwardB}, {9'd0, exp_l});
    exp_l = {1'b1, 6'd2, 16'h0102}; check_eq("six_C2", {9'd0, forwardC}, {9'd0, exp_l});
    exp_l = {1'b1, 6'd3, 16'h0103}; check_eq("six_D3", {9'd0, forwardD}, {9'd0, exp_l});
    tick();
    exp_l = {1'b1, 6'd4, 16'h0104}; check_eq("six_A4", {9'd0, forwardA}, {9'd0, exp_l});
    exp_l = {1'b1, 6'd5, 16'h0105}; check_eq("six_B5", {9'd0, forwardB}, {9'd0, exp_l});
    check_eq("six_C0", {9'd0, forwardC}, 32'd0);
    check_eq("six_D0", {9'd0, forwardD}, 32'd0);
    check_eq("six_busy", {31'd0, busy}, 32'd0);

    // Fairness: all sources kept non-empty; rr should have wrapped to 0
    for (int i = 0; i < 6; i++) begin grants[i] = 0; load_src(i); end
    src_valid = 6'h3F;
    tick();
    refresh();
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq($sformatf("fair_A_valid_%0d", c), {31'd0, forwardA[22]}, 32'd1);
      check_eq($sformatf("fair_A_src_%0d", c), {29'd0, forwardA[21:19]}, 32'(a_seq[c]));
      if (forwardA[22]) grants[forwardA[21:19]]++;
      if (forwardB[22]) grants[forwardB[21:19]]++;
      if (forwardC[22]) grants[forwardC[21:19]]++;
      if (forwardD[22]) grants[forwardD[21:19]]++;
      refresh();
    end
    src_valid = '0;
    for (int i = 0; i < 6; i++) check_eq($sformatf("fair_grants_%0d", i), 32'(grants[i]), 32'd4);
    wait_idle();

    // Backpressure on source 1 while the others stay busy
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) load_src(i);
    src_valid = 6'b111101;
    tick(); refresh();
    tick(); refresh();
    tick(); refresh();
    src_valid[1] = 1'b1;
    tick();
    check_eq("bp_acc1", {31'd0, acc_q[1]}, 32'd1);
    check_eq("bp_ready_after1", {31'd0, src_ready[1]}, 32'd1);
    refresh();
    tick();
    check_eq("bp_acc2", {31'd0, acc_q[1]}, 32'd1);
    check_eq("bp_ready_after2", {31'd0, src_ready[1]}, 32'd0);
    refresh();
    tick();
    check_eq("bp_held", {31'd0, acc_q[1]}, 32'd0);
    check_eq("bp_ready_after_pop", {31'd0, src_ready[1]}, 32'd1);
    check_eq("bp_A_src1", {29'd0, forwardA[21:19]}, 32'd1);
    refresh();
    tick();
    check_eq("bp_acc3", {31'd0, acc_q[1]}, 32'd1);
    src_valid = '0;
    wait_idle();

    // Flush with five loaded entries and a coincident push on source 5
    for (int i = 0; i < 5; i++) begin seq[i] = 8'h80; load_src(i); end
    src_valid = 6'b011111;
    tick();
    set_src(5, 6'h3F, 16'hDEAD);
    src_valid = 6'b100000;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src_valid = '0;
    check_lanes_zero("flush_lane");
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    check_eq("flush_ready", {26'd0, src_ready}, 32'h3F);
    for (int n = 0; n < 3; n++) begin
      tick();
      check_eq($sformatf("post_flush_A_%0d", n), {9'd0, forwardA}, 32'd0);
      check_eq($sformatf("post_flush_busy_%0d", n), {31'd0, busy}, 32'd0);
    end

    begin
      int left;
      left = 0;
      for (int i = 0; i < 6; i++) left += sb[i].size();
      check_eq("sb_empty", 32'(left), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
